coin_vend_controller: RTL

//   Parametrised coin accumulator with vend and change return. Sums quarter,

---
 rtl/coin_vend_controller_if.sv | 32 +++
 rtl/coin_vend_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/coin_vend_controller_if.sv
// Coin-vend controller bus: coin-slot inputs, vend/cancel requests and the
// registered credit / pulse / busy outputs grouped into one bundle.
//   master : front end / bench side (drives coins, price, vend_req, cancel)
//   slave  : controller side (drives credit, pulses, busy)
interface coin_vend_controller_if #(
   parameter int WIDTH = 10
);
   logic             in_q;
   logic             in_d;
   logic             in_n;
   logic [WIDTH-1:0] price;
   logic             vend_req;
   logic             cancel;
   logic [WIDTH-1:0] credit;
   logic             coin_reject;
   logic             vend_ok;
   logic             vend_deny;
   logic             out_q;
   logic             out_d;
   logic             out_n;
   logic             busy;

   modport master (
      output in_q, in_d, in_n, price, vend_req, cancel,
      input  credit, coin_reject, vend_ok, vend_deny, out_q, out_d, out_n, busy
   );

   modport slave (
      input  in_q, in_d, in_n, price, vend_req, cancel,
      output credit, coin_reject, vend_ok, vend_deny, out_q, out_d, out_n, busy
   );
endinterface

// File: rtl/coin_vend_controller.sv
// Coin accumulator with vend and change return.
// Sums quarter/dime/nickel inputs into a credit register capped at
// MAX_CREDIT (a coin group that would exceed the cap is refused whole).
// A vend request debits the price; any remainder, or the whole credit on
// cancel, is paid back greedily one coin per cycle while busy is high.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : coin_vend_controller_if.slave (coins, price, vend_req, cancel in;
//          credit, coin_reject, vend_ok, vend_deny, out_q/d/n, busy out)
// All outputs are registered: they reflect the inputs sampled one edge earlier.
module coin_vend_controller #(
   parameter int WIDTH      = 10,
   parameter int Q_VALUE    = 25,
   parameter int D_VALUE    = 10,
   parameter int N_VALUE    = 5,
   parameter int MAX_CREDIT = 500
) (
   input logic                  clk,
   input logic                  rst,
   coin_vend_controller_if.slave bus
);
   localparam int XW = WIDTH + 2;

   typedef enum logic {IDLE, CHANGE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] credit_q, credit_d;
   logic             reject_q, reject_d;
   logic             ok_q, ok_d;
   logic             deny_q, deny_d;
   logic             oq_q, oq_d;
   logic             od_q, od_d;
   logic             on_q, on_d;

   logic             any_coin;
   logic [XW-1:0]    coin_sum;
   logic [XW-1:0]    credit_sum;
   logic             sum_fits;
   logic             can_vend;
   logic             ge_q, ge_d, ge_n;

   // Sum is formed two bits wider than credit so a full group on top of a
   // near-max credit cannot wrap before the cap check.
   assign any_coin   = bus.in_q | bus.in_d | bus.in_n;
   assign coin_sum   = (bus.in_q ? XW'(Q_VALUE) : '0)
                     + (bus.in_d ? XW'(D_VALUE) : '0)
                     + (bus.in_n ? XW'(N_VALUE) : '0);
   assign credit_sum = XW'(credit_q) + coin_sum;
   assign sum_fits   = credit_sum <= XW'(MAX_CREDIT);
   assign can_vend   = credit_q >= bus.price;

   assign ge_q = credit_q >= WIDTH'(Q_VALUE);
   assign ge_d = credit_q >= WIDTH'(D_VALUE);
   assign ge_n = credit_q >= WIDTH'(N_VALUE);

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         credit_q <= '0;
         reject_q <= 1'b0;
         ok_q     <= 1'b0;
         deny_q   <= 1'b0;
         oq_q     <= 1'b0;
         od_q     <= 1'b0;
         on_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         reject_q <= reject_d;
         ok_q     <= ok_d;
         deny_q   <= deny_d;
         oq_q     <= oq_d;
         od_q     <= od_d;
         on_q     <= on_d;
      end
   end

   // Next state and credit
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      case (state_q)
         IDLE: begin
            // cancel > vend_req > coins
            if (bus.cancel) begin
               if (credit_q != '0) state_d = CHANGE;
            end else if (bus.vend_req) begin
               if (can_vend) begin
                  credit_d = credit_q - bus.price;
                  if (credit_q != bus.price) state_d = CHANGE;
               end
            end else if (any_coin && sum_fits) begin
               credit_d = credit_sum[WIDTH-1:0];
            end
         end
         CHANGE: begin
            if (ge_q)      credit_d = credit_q - WIDTH'(Q_VALUE);
            else if (ge_d) credit_d = credit_q - WIDTH'(D_VALUE);
            else if (ge_n) credit_d = credit_q - WIDTH'(N_VALUE);
            else           credit_d = '0;  // sub-nickel residue is forfeited
            if (credit_d == '0) state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase
   end

   // Next pulse outputs
   always_comb begin
      reject_d = 1'b0;
      ok_d     = 1'b0;
      deny_d   = 1'b0;
      oq_d     = 1'b0;
      od_d     = 1'b0;
      on_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cancel || bus.vend_req) begin
               // A request takes the cycle; coins alongside it are refused.
               reject_d = any_coin;
               if (!bus.cancel) begin
                  ok_d   = can_vend;
                  deny_d = !can_vend;
               end
            end else begin
               reject_d = any_coin && !sum_fits;
            end
         end
         CHANGE: begin
            reject_d = any_coin;
            oq_d     = ge_q;
            od_d     = !ge_q && ge_d;
            on_d     = !ge_q && !ge_d && ge_n;
         end
         default: ;
      endcase
   end

   assign bus.credit      = credit_q;
   assign bus.coin_reject = reject_q;
   assign bus.vend_ok     = ok_q;
   assign bus.vend_deny   = deny_q;
   assign bus.out_q       = oq_q;
   assign bus.out_d       = od_q;
   assign bus.out_n       = on_q;
   assign bus.busy        = (state_q == CHANGE);
endmodule
